fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage program-counter controller directly upstream of InstructionMemory. It drives the memory address, selects the next PC, and keeps the PC aligned with the registered instruction output.
- InstructionMemory has 1-cycle read latency and holds its output under stall. This block produces the pc_if, valid and kill qualifiers that the IF/ID register uses alongside that instruction.
- Redirects (JMP/CALL, taken branch, RET) come from decode as precomputed targets and a 2-bit select.

Parameters:
- ADDR_W, 16, PC/address width; PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 16'h0000, PC loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode; same signal drives InstructionMemory.stall.
- pc_src  in  2  next-PC select: 00 SEQ, 01 JMP (JMP/CALL), 10 BR (taken branch), 11 RET.
- jump_target  in  ADDR_W  absolute JMP/CALL target ({pc_id[15:12], imm12}, formed in decode).
- branch_target  in  ADDR_W  taken-branch target (pc_id + sign-extended imm5).
- return_target  in  ADDR_W  RET target (value of R7 from decode).
- pc  out  ADDR_W  current fetch address; connects to InstructionMemory.address.
- pc_if  out  ADDR_W  address of the instruction currently on InstructionMemory.instruction.
- pc_plus1_if  out  ADDR_W  pc_if + 1 (CALL link value).
- fetch_valid  out  1  instruction output is valid on-path this cycle.
- kill  out  1  equals !fetch_valid; IF/ID inserts a NOP when high.
- redirect_count  out  CNT_W  saturating count of accepted redirects.

Behaviour:
- Reset (synchronous): takes effect when reset=1 at a rising edge.
  - Values loaded: pc=RESET_PC, pc_if=RESET_PC, state=BOOT, redirect_count=0.
  - Resulting outputs: pc_plus1_if=RESET_PC+1, fetch_valid=0, kill=1.
  - Reset overrides stall and pc_src, including mid-redirect.
- States:
  - BOOT: the memory output does not yet hold the instruction at pc.
  - RUN: normal fetch.
  - FLUSH: the memory output is the wrong-path fetch issued in the redirect cycle.
- fetch_valid (combinational) = (state==RUN) && (pc_src==SEQ).
  - With pc_src!=SEQ, the instruction currently in IF is the fall-through after the control instruction in ID and is squashed (no delay slot).
- Next-PC priority:
  1. reset
  2. redirect (pc_src!=SEQ), which wins over stall
  3. stall (hold)
  4. pc+1, wrapping FFFF->0000
- Redirect cycle (pc_src!=SEQ, no reset):
  - pc <= the selected target; pc_if is unchanged.
  - state <= FLUSH.
  - redirect_count <= redirect_count+1, saturating at all-ones.
- Stall without redirect:
  - pc, pc_if and state hold.
  - fetch_valid follows the held state; the IF/ID register holds independently.
- Normal cycle (pc_src==SEQ, !stall):
  - pc_if <= pc (the same edge where the memory latches instruction[pc]).
  - pc <= pc+1.
  - State transitions: BOOT->RUN, FLUSH->RUN, RUN->RUN.
- FLUSH held by stall remains FLUSH: memory output is not refreshed, so it stays invalid.
- Redirect in BOOT or FLUSH is legal; the new target replaces pc and the state becomes FLUSH.
- Latency:
  - After reset deassert with no stall, the first valid instruction (RESET_PC) appears one cycle later.
  - After a redirect with no stall, the target instruction is valid two cycles after the redirect cycle.
- pc_plus1_if = pc_if+1, modulo 2^ADDR_W.

Decomposition:
- Shared package (fetch_pkg):
  - PC_SEQ=2'b00, PC_JMP=2'b01, PC_BR=2'b10, PC_RET=2'b11.
  - State encodings BOOT/RUN/FLUSH.
  - Default RESET_PC.
- One natural sub-module: next_pc_mux, combinational. It selects among pc+1, jump_target, branch_target and return_target from pc_src. The top level holds the registers, FSM and counter.

Test Plan:
- Reset then run, stall=0, pc_src=SEQ:
  - Cycle 0: pc=0, kill=1.
  - Cycle 1: pc=1, pc_if=0, fetch_valid=1.
  - Cycle 2: pc=2, pc_if=1, pc_plus1_if=2.
- JMP from RUN with pc=6, pc_src=01, jump_target=000A for one cycle:
  - That cycle: kill=1.
  - Next cycle: pc=000A, FLUSH, kill=1.
  - Following cycle: pc_if=000A, fetch_valid=1; redirect_count=1.
- Stall held 3 cycles at pc=4, pc_if=3:
  - pc and pc_if hold, fetch_valid stays 1.
  - After release: pc=5, pc_if=4.
- Redirect during stall (stall=1, pc_src=11, return_target=0006):
  - pc=0006 next cycle despite stall.
  - With stall still 1, state stays FLUSH and kill=1.
  - First non-stall cycle: pc_if=0006 afterwards, valid.
- Wrap and saturation:
  - pc=FFFF, SEQ -> pc=0000.
  - With CNT_W=2, four BR redirects -> redirect_count=3, holds at 3.
- Reset asserted mid-FLUSH with pc_src=10 simultaneous:
  - Next cycle pc=RESET_PC, BOOT, kill=1, redirect_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions.
// Next-PC select codes, FSM states and default reset PC.
package fetch_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_RET = 2'b11;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_next_pc_mux.sv
// Combinational next-PC select.
// Chooses pc+1 or one of the decode-supplied redirect targets.
module next_pc_mux
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] return_target,
    output logic [ADDR_W-1:0] next_pc
);

    // Select source; pc+1 wraps naturally at the width.
    always_comb begin
        next_pc = pc + ADDR_W'(1);
        unique case (pc_src)
            PC_SEQ: next_pc = pc + ADDR_W'(1);
            PC_JMP: next_pc = jump_target;
            PC_BR:  next_pc = branch_target;
            PC_RET: next_pc = return_target;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC controller in front of a 1-cycle instruction memory.
// Tracks which address the memory output belongs to and whether it is on-path.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] return_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_if,
    output logic [ADDR_W-1:0] pc_plus1_if,
    output logic              fetch_valid,
    output logic              kill,
    output logic [CNT_W-1:0]  redirect_count
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;

    assign redirect = (pc_src != PC_SEQ);

    next_pc_mux #(
        .ADDR_W(ADDR_W)
    ) u_mux (
        .pc            (pc),
        .pc_src        (pc_src),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .return_target (return_target),
        .next_pc       (next_pc)
    );

    // Redirect always lands in FLUSH; an unstalled fetch refreshes the output.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = FLUSH;
        end else if (!stall) begin
            state_d = RUN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // PC pair; redirect beats stall, pc_if follows pc only on a real fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            pc_if <= RESET_PC;
        end else if (redirect) begin
            pc <= next_pc;
        end else if (!stall) begin
            pc    <= next_pc;
            pc_if <= pc;
        end
    end

    // Saturating count of accepted redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_count <= '0;
        end else if (redirect && (redirect_count != '1)) begin
            redirect_count <= redirect_count + CNT_W'(1);
        end
    end

    assign pc_plus1_if = pc_if + ADDR_W'(1);
    assign fetch_valid = (state_q == RUN) && !redirect;
    assign kill        = !fetch_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit.
// Directed scenarios followed by random traffic against a reference model.
module tb_fetch_pc_unit;

    localparam int CNT_W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [15:0] jump_target = '0;
    logic [15:0] branch_target = '0;
    logic [15:0] return_target = '0;
    logic [15:0] pc;
    logic [15:0] pc_if;
    logic [15:0] pc_plus1_if;
    logic        fetch_valid;
    logic        kill;
    logic [CNT_W-1:0] redirect_count;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: fetch address, address of memory output,
    // whether that output is the on-path instruction, redirect tally.
    int  m_pc;
    int  m_pc_if;
    bit  m_out_ok;
    int  m_cnt;
    bit  m_known = 0;

    fetch_pc_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .pc_src         (pc_src),
        .jump_target    (jump_target),
        .branch_target  (branch_target),
        .return_target  (return_target),
        .pc             (pc),
        .pc_if          (pc_if),
        .pc_plus1_if    (pc_plus1_if),
        .fetch_valid    (fetch_valid),
        .kill           (kill),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    task automatic compare_all();
        bit v;
        v = m_out_ok && (pc_src == 2'b00);
        check("pc", pc, 16'(m_pc));
        check("pc_if", pc_if, 16'(m_pc_if));
        check("pc_plus1_if", pc_plus1_if, 16'((m_pc_if + 1) % 65536));
        check("fetch_valid", 16'(fetch_valid), 16'(v));
        check("kill", 16'(kill), 16'(!v));
        check("redirect_count", 16'(redirect_count), 16'(m_cnt));
    endtask

    task automatic model_step(input logic r, input logic s,
                              input logic [1:0] src, input int jt,
                              input int bt, input int rt);
        int cmax;
        cmax = (1 << CNT_W) - 1;
        if (r) begin
            m_pc = 0;
            m_pc_if = 0;
            m_out_ok = 0;
            m_cnt = 0;
            m_known = 1;
        end else if (src != 2'b00) begin
            m_pc = (src == 2'b01) ? jt : (src == 2'b10) ? bt : rt;
            m_out_ok = 0;
            if (m_cnt < cmax) m_cnt = m_cnt + 1;
        end else if (!s) begin
            m_pc_if = m_pc;
            m_pc = (m_pc + 1) % 65536;
            m_out_ok = 1;
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [1:0] src,
                       input logic [15:0] jt, input logic [15:0] bt,
                       input logic [15:0] rt);
        @(negedge clk);
        reset = r;
        stall = s;
        pc_src = src;
        jump_target = jt;
        branch_target = bt;
        return_target = rt;
        #1;
        if (m_known) compare_all();
        @(posedge clk);
        model_step(r, s, src, int'(jt), int'(bt), int'(rt));
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then run.
        cyc(1, 0, 2'b00, 0, 0, 0);
        cyc(1, 0, 2'b00, 0, 0, 0);
        check("rst_pc", pc, 16'h0000);
        check("rst_kill", 16'(kill), 16'h1);
        check("rst_cnt", 16'(redirect_count), 16'h0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        check("run1_pc", pc, 16'h0001);
        check("run1_pc_if", pc_if, 16'h0000);
        check("run1_valid", 16'(fetch_valid), 16'h1);
        cyc(0, 0, 2'b00, 0, 0, 0);
        check("run2_pc", pc, 16'h0002);
        check("run2_plus1", pc_plus1_if, 16'h0002);
        cyc(0, 0, 2'b00, 0, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        // Stall at pc=4, pc_if=3.
        repeat (3) cyc(0, 1, 2'b00, 0, 0, 0);
        check("stall_pc", pc, 16'h0004);
        check("stall_pc_if", pc_if, 16'h0003);
        check("stall_valid", 16'(fetch_valid), 16'h1);
        cyc(0, 0, 2'b00, 0, 0, 0);
        check("rel_pc", pc, 16'h0005);
        check("rel_pc_if", pc_if, 16'h0004);
        cyc(0, 0, 2'b00, 0, 0, 0);
        // JMP from pc=6.
        cyc(0, 0, 2'b01, 16'h000A, 16'h1234, 16'h4321);
        check("jmp_pc", pc, 16'h000A);
        check("jmp_kill", 16'(kill), 16'h1);
        cyc(0, 0, 2'b00, 0, 0, 0);
        check("jmp_pc_if", pc_if, 16'h000A);
        check("jmp_valid", 16'(fetch_valid), 16'h1);
        check("jmp_cnt", 16'(redirect_count), 16'h1);
        // RET while stalled.
        cyc(0, 1, 2'b11, 16'h1111, 16'h2222, 16'h0006);
        check("ret_pc", pc, 16'h0006);
        cyc(0, 1, 2'b00, 0, 0, 0);
        check("ret_hold_kill", 16'(kill), 16'h1);
        cyc(0, 1, 2'b00, 0, 0, 0);
        check("ret_hold_kill2", 16'(kill), 16'h1);
        cyc(0, 0, 2'b00, 0, 0, 0);
        check("ret_pc_if", pc_if, 16'h0006);
        check("ret_valid", 16'(fetch_valid), 16'h1);
        // PC wrap.
        cyc(0, 0, 2'b01, 16'hFFFF, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        check("wrap_pc", pc, 16'h0000);
        check("wrap_plus1", pc_plus1_if, 16'h0000);
        // Counter saturation.
        repeat (4) cyc(0, 0, 2'b10, 0, 16'h0040, 0);
        check("sat_cnt", 16'(redirect_count), 16'h3);
        cyc(0, 0, 2'b10, 0, 16'h0050, 0);
        check("sat_hold", 16'(redirect_count), 16'h3);
        // Reset mid-FLUSH with a simultaneous branch.
        cyc(1, 0, 2'b10, 0, 16'h0077, 0);
        check("rstf_pc", pc, 16'h0000);
        check("rstf_kill", 16'(kill), 16'h1);
        check("rstf_cnt", 16'(redirect_count), 16'h0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       s;
            logic [1:0] src;
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 3) == 0);
            src = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3))
                                              : 2'b00;
            cyc(r, s, src, 16'($urandom), 16'($urandom), 16'($urandom));
        end
        cyc(0, 0, 2'b00, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
